// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: exe commands, ARM opcodes,
// condition codes, instruction modes and the control bundle.
package id_stage_pkg;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    localparam logic [3:0] EXE_NOP  = 4'b0000;
    localparam logic [3:0] EXE_MOV  = 4'b0001;
    localparam logic [3:0] EXE_ADD  = 4'b0010;
    localparam logic [3:0] EXE_ADC  = 4'b0011;
    localparam logic [3:0] EXE_SUB  = 4'b0100;
    localparam logic [3:0] EXE_SBC  = 4'b0101;
    localparam logic [3:0] EXE_AND  = 4'b0110;
    localparam logic [3:0] EXE_ORR  = 4'b0111;
    localparam logic [3:0] EXE_EOR  = 4'b1000;
    localparam logic [3:0] EXE_MVN  = 4'b1001;
    localparam logic [3:0] EXE_LDST = 4'b0010;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       b;
        logic       s;
    } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// IF/ID input and ID/EX output bundle of the decode stage.
interface id_stage_if;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;

    modport master (
        input  pc_in, instruction,
        output pc, val_rn, val_rm, imm, shift_operand, signed_imm_24,
        output dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s,
        output src1, src2, two_src
    );

    modport slave (
        output pc_in, instruction,
        input  pc, val_rn, val_rm, imm, shift_operand, signed_imm_24,
        input  dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s,
        input  src1, src2, two_src
    );
endinterface

// File: rtl/register_file.sv
// R0..R14 with async reset to index values; R15 reads as PC+4.
// A read of the register being written this cycle sees the new value.
module register_file
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_rd_addr1,
    input  logic [3:0]  i_rd_addr2,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data1,
    output logic [31:0] o_rd_data2
);

    logic [31:0] r_regs [15];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= 32'(i);
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (i_wr_en && i_wr_addr == 4'(i)) begin
                    r_regs[i] <= i_wr_data;
                end
            end
        end
    end

    function automatic logic [31:0] rd_port(input logic [3:0] a);
        logic [31:0] v;
        v = i_pc;
        if (a != 4'hF) begin
            v = (i_wr_en && a == i_wr_addr) ? i_wr_data : r_regs[a];
        end
        return v;
    endfunction

    assign o_rd_data1 = rd_port(i_rd_addr1);
    assign o_rd_data2 = rd_port(i_rd_addr2);

endmodule

// File: rtl/id_stage.sv
// ARM-style decode stage: register read, condition check and
// control decode, all combinational around the register file.
module id_stage
    import id_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i_status,
    input  logic          i_hazard,
    input  logic          i_wb_en,
    input  logic [3:0]    i_wb_dest,
    input  logic [31:0]   i_wb_value,
    id_stage_if.master    io_id
);

    logic [31:0] w_ins;
    logic [3:0]  w_cond;
    logic [3:0]  w_opcode;
    logic        w_s_bit;
    logic [3:0]  w_rn;
    logic [3:0]  w_rm;
    logic        w_n, w_z, w_c, w_v;
    logic        w_cond_ok;
    mode_t       w_mode;
    ctrl_t       w_ctrl;
    ctrl_t       w_out;

    assign w_ins    = io_id.instruction;
    assign w_cond   = w_ins[31:28];
    assign w_mode   = mode_t'(w_ins[27:26]);
    assign w_opcode = w_ins[24:21];
    assign w_s_bit  = w_ins[20];
    assign {w_n, w_z, w_c, w_v} = i_status;

    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            COND_EQ: w_cond_ok = w_z;
            COND_NE: w_cond_ok = ~w_z;
            COND_CS: w_cond_ok = w_c;
            COND_CC: w_cond_ok = ~w_c;
            COND_MI: w_cond_ok = w_n;
            COND_PL: w_cond_ok = ~w_n;
            COND_VS: w_cond_ok = w_v;
            COND_VC: w_cond_ok = ~w_v;
            COND_HI: w_cond_ok = w_c & ~w_z;
            COND_LS: w_cond_ok = ~w_c | w_z;
            COND_GE: w_cond_ok = (w_n == w_v);
            COND_LT: w_cond_ok = (w_n != w_v);
            COND_GT: w_cond_ok = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ok = w_z | (w_n != w_v);
            COND_AL: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        unique case (w_mode)
            MODE_DP: begin
                w_ctrl.s     = w_s_bit;
                w_ctrl.wb_en = 1'b1;
                unique case (w_opcode)
                    OP_MOV: w_ctrl.exe_cmd = EXE_MOV;
                    OP_MVN: w_ctrl.exe_cmd = EXE_MVN;
                    OP_ADD: w_ctrl.exe_cmd = EXE_ADD;
                    OP_ADC: w_ctrl.exe_cmd = EXE_ADC;
                    OP_SUB: w_ctrl.exe_cmd = EXE_SUB;
                    OP_SBC: w_ctrl.exe_cmd = EXE_SBC;
                    OP_AND: w_ctrl.exe_cmd = EXE_AND;
                    OP_ORR: w_ctrl.exe_cmd = EXE_ORR;
                    OP_EOR: w_ctrl.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        w_ctrl.exe_cmd = EXE_SUB;
                        w_ctrl.wb_en   = 1'b0;
                        w_ctrl.s       = 1'b1;
                    end
                    OP_TST: begin
                        w_ctrl.exe_cmd = EXE_AND;
                        w_ctrl.wb_en   = 1'b0;
                        w_ctrl.s       = 1'b1;
                    end
                    default: begin
                        w_ctrl.exe_cmd = EXE_NOP;
                        w_ctrl.wb_en   = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                w_ctrl.exe_cmd  = EXE_LDST;
                w_ctrl.mem_r_en = w_s_bit;
                w_ctrl.wb_en    = w_s_bit;
                w_ctrl.mem_w_en = ~w_s_bit;
            end
            MODE_BR:  w_ctrl.b = 1'b1;
            MODE_RSV: w_ctrl = '0;
        endcase
    end

    // Squash only the control bundle; operands keep flowing for forwarding.
    assign w_out = (w_cond_ok && !i_hazard) ? w_ctrl : '0;

    assign w_rn = w_ins[19:16];
    assign w_rm = w_ctrl.mem_w_en ? w_ins[15:12] : w_ins[3:0];

    register_file u_rf (
        .clk        (clk),
        .rst        (rst),
        .i_pc       (io_id.pc_in),
        .i_rd_addr1 (w_rn),
        .i_rd_addr2 (w_rm),
        .i_wr_en    (i_wb_en),
        .i_wr_addr  (i_wb_dest),
        .i_wr_data  (i_wb_value),
        .o_rd_data1 (io_id.val_rn),
        .o_rd_data2 (io_id.val_rm)
    );

    assign io_id.pc            = io_id.pc_in;
    assign io_id.imm           = w_ins[25];
    assign io_id.shift_operand = w_ins[11:0];
    assign io_id.signed_imm_24 = w_ins[23:0];
    assign io_id.dest          = w_ins[15:12];
    assign io_id.exe_cmd       = w_out.exe_cmd;
    assign io_id.mem_r_en      = w_out.mem_r_en;
    assign io_id.mem_w_en      = w_out.mem_w_en;
    assign io_id.wb_en         = w_out.wb_en;
    assign io_id.b             = w_out.b;
    assign io_id.s             = w_out.s;
    assign io_id.src1          = w_rn;
    assign io_id.src2          = w_rm;
    assign io_id.two_src       = ~w_ins[25] | w_ctrl.mem_w_en;

endmodule

// File: tb/tb_id_stage.sv
// Directed checks of id_stage decode, register file and reset behaviour.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  status;
    logic        hazard;
    logic        wb_en_in;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    int          total;
    int          bad;

    id_stage_if bus ();

    id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .i_status   (status),
        .i_hazard   (hazard),
        .i_wb_en    (wb_en_in),
        .i_wb_dest  (wb_dest),
        .i_wb_value (wb_value),
        .io_id      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {23'd0, bus.exe_cmd, bus.mem_r_en, bus.mem_w_en,
                bus.wb_en, bus.b, bus.s};
    endfunction

    // control packed as {exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}
    function automatic logic [31:0] c(input logic [3:0] e, input logic r,
                                      input logic w, input logic wb,
                                      input logic b, input logic s);
        return {23'd0, e, r, w, wb, b, s};
    endfunction

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        status = 4'b0000;
        hazard = 1'b0;
        wb_en_in = 1'b0;
        wb_dest = 4'd0;
        wb_value = 32'd0;
        bus.pc_in = 32'h0000_1004;
        bus.instruction = 32'h0005_0000;
        #1;
        chk("rst_r5", bus.val_rn, 32'd5);
        chk("rst_rm0", bus.val_rm, 32'd0);
        chk("zero_ins_z0", ctl(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.instruction = 32'h000E_0000;
        #1;
        chk("rst_r14", bus.val_rn, 32'd14);
        status = 4'b0100;
        #1;
        chk("zero_ins_z1", ctl(), c(4'b0110, 0, 0, 1, 0, 0));

        status = 4'b0000;
        bus.instruction = 32'hE281_1005;
        #1;
        chk("add_ctl", ctl(), c(4'b0010, 0, 0, 1, 0, 0));
        chk("add_imm", 32'(bus.imm), 32'd1);
        chk("add_shop", 32'(bus.shift_operand), 32'h005);
        chk("add_dest", 32'(bus.dest), 32'd1);
        chk("add_two_src", 32'(bus.two_src), 32'd0);
        chk("add_rn", bus.val_rn, 32'd1);
        chk("pc", bus.pc, 32'h0000_1004);

        @(negedge clk);
        bus.instruction = 32'hE083_0000;
        wb_en_in = 1'b1;
        wb_dest = 4'd3;
        wb_value = 32'hDEAD_BEEF;
        #1;
        chk("bypass_comb", bus.val_rn, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        chk("bypass_edge", bus.val_rn, 32'hDEAD_BEEF);
        wb_en_in = 1'b0;
        #1;
        chk("r3_stored", bus.val_rn, 32'hDEAD_BEEF);

        @(negedge clk);
        wb_en_in = 1'b1;
        wb_dest = 4'd15;
        wb_value = 32'h5555_5555;
        bus.instruction = 32'hE08F_1003;
        @(posedge clk);
        #1;
        wb_en_in = 1'b0;
        #1;
        chk("r15_pc", bus.val_rn, 32'h0000_1004);

        bus.instruction = 32'h0A00_0004;
        status = 4'b0000;
        #1;
        chk("beq_z0", ctl(), 32'd0);
        status = 4'b0100;
        #1;
        chk("beq_z1", ctl(), c(4'b0000, 0, 0, 0, 1, 0));
        chk("beq_imm24", 32'(bus.signed_imm_24), 32'h000004);

        status = 4'b0000;
        bus.instruction = 32'hE582_1000;
        #1;
        chk("str_ctl", ctl(), c(4'b0010, 0, 1, 0, 0, 0));
        chk("str_src2", 32'(bus.src2), 32'd1);
        chk("str_two_src", 32'(bus.two_src), 32'd1);
        chk("str_rm", bus.val_rm, 32'd1);
        chk("str_rn", bus.val_rn, 32'd2);

        bus.instruction = 32'hE592_1000;
        #1;
        chk("ldr_ctl", ctl(), c(4'b0010, 1, 0, 1, 0, 0));
        chk("ldr_src2", 32'(bus.src2), 32'd0);

        bus.instruction = 32'hE082_1003;
        hazard = 1'b1;
        #1;
        chk("haz_ctl", ctl(), 32'd0);
        chk("haz_rn", bus.val_rn, 32'd2);
        chk("haz_rm", bus.val_rm, 32'hDEAD_BEEF);
        chk("haz_src1", 32'(bus.src1), 32'd2);
        hazard = 1'b0;

        bus.instruction = 32'hE152_0003;
        #1;
        chk("cmp_ctl", ctl(), c(4'b0100, 0, 0, 0, 0, 1));
        bus.instruction = 32'hE111_0003;
        #1;
        chk("tst_ctl", ctl(), c(4'b0110, 0, 0, 0, 0, 1));
        bus.instruction = 32'hE1F0_1002;
        #1;
        chk("mvns_ctl", ctl(), c(4'b1001, 0, 0, 1, 0, 1));
        bus.instruction = 32'hE062_1003;
        #1;
        chk("undef_ctl", ctl(), c(4'b0000, 0, 0, 0, 0, 0));

        bus.instruction = 32'hC082_1003;
        status = 4'b0000;
        #1;
        chk("gt_pass", ctl(), c(4'b0010, 0, 0, 1, 0, 0));
        status = 4'b1000;
        #1;
        chk("gt_fail", ctl(), 32'd0);
        status = 4'b1001;
        #1;
        chk("gt_nv_eq", ctl(), c(4'b0010, 0, 0, 1, 0, 0));
        bus.instruction = 32'h8082_1003;
        status = 4'b0010;
        #1;
        chk("hi_pass", ctl(), c(4'b0010, 0, 0, 1, 0, 0));
        status = 4'b0110;
        #1;
        chk("hi_fail", ctl(), 32'd0);
        bus.instruction = 32'hF082_1003;
        #1;
        chk("never", ctl(), 32'd0);

        @(negedge clk);
        wb_en_in = 1'b1;
        wb_dest = 4'd4;
        wb_value = 32'h0000_1234;
        @(posedge clk);
        #1;
        wb_en_in = 1'b0;
        bus.instruction = 32'hE084_1003;
        #1;
        chk("r4_write", bus.val_rn, 32'h0000_1234);

        @(negedge clk);
        wb_en_in = 1'b1;
        wb_value = 32'h5555_5555;
        rst = 1'b1;
        @(posedge clk);
        #1;
        wb_en_in = 1'b0;
        #1;
        chk("rst_lost_write", bus.val_rn, 32'd4);
        chk("rst_r3", bus.val_rm, 32'd3);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 pc_in, instruction  in  32 each  PC+4 and instruction from the IF/ID register.
REQ-004 status  in  4  NZCV flags from the status register (N=bit3, V=bit0).
REQ-005 hazard  in  1  high stalls issue; the control outputs become a bubble.
REQ-006 wb_en_in, wb_dest, wb_value  in  1/4/32  write-back port from the WB stage.
REQ-007 pc  out  32  equals pc_in.
REQ-008 val_rn, val_rm  out  32 each  register operands.
REQ-009 imm  out  1, shift_operand  out  12, signed_imm_24  out  24  equal instruction[25], [11:0] and [23:0].
REQ-010 dest  out  4  equals instruction[15:12].
REQ-011 exe_cmd  out  4, mem_r_en, mem_w_en, wb_en, b, s  out  1 each  control bundle.
REQ-012 src1, src2  out  4, two_src  out  1  source register numbers for hazard detection.

Function
REQ-013 Register file: 15 x 32-bit registers R0..R14; R15 reads return pc_in.
REQ-014 Write: if wb_en_in=1 and wb_dest!=15, register[wb_dest] takes wb_value on the rising clk edge.
REQ-015 Reads are combinational. A read whose address equals wb_dest while wb_en_in=1 returns wb_value (write-through bypass).
REQ-016 rn = instruction[19:16].
REQ-017 rm = (mem_w_en ? instruction[15:12] : instruction[3:0]).
REQ-018 src1 = rn and src2 = rm.
REQ-019 mode = instruction[27:26] (00 data processing, 01 memory, 10 branch); opcode = instruction[24:21]; s_bit = instruction[20].
REQ-020 exe_cmd mapping:
  - MOV(1101)=0001, MVN(1111)=1001
  - ADD(0100)=0010, ADC(0101)=0011
  - SUB(0010)=0100, SBC(0110)=0101
  - AND(0000)=0110, ORR(1100)=0111, EOR(0001)=1000
  - CMP(1010)=0100, TST(1000)=0110
  - LDR/STR=0010
  - branch and undefined opcodes=0000
REQ-021 wb_en=1 for all data-processing ops except CMP/TST, and for LDR. mem_r_en=1 for LDR (mode 01, s_bit=1). mem_w_en=1 for STR (mode 01, s_bit=0). b=1 for mode 10.
REQ-022 Output s = s_bit for data processing; s=1 forced for CMP/TST; s=0 for memory and branch.
REQ-023 Condition check on instruction[31:28]:
  - EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per the ARM definitions
  - 1110=always
  - 1111=never
REQ-024 If the condition fails or hazard=1: exe_cmd, mem_r_en, mem_w_en, wb_en, b and s are all 0. Operand and datapath outputs are unaffected.
REQ-025 two_src = ~imm or mem_w_en.
REQ-026 Decode latency is zero; the only registered state is the register file.
REQ-027 A 32'b0 instruction (flush bubble) decodes to AND with cond EQ. When Z=0 it must yield all-zero control; no special-casing of a zero instruction is permitted.

Reset
REQ-028 On rst, register[i] = i for i=0..14, asynchronously; all writes are ignored while rst=1.
REQ-029 Reset asserted mid-write takes priority; the write is lost.

Structure
REQ-030 A shared package holds: exe_cmd constants, ARM opcode constants, condition-code constants, and the mode encoding.
REQ-031 Sub-module register_file (2 read ports, 1 write port, bypass). Condition check and control decode stay in id_stage.

Verification
REQ-032 Reset, then read R5 (instruction rn=5) -> val_rn=5.
REQ-033 0xE2811005 (ADD R1,R1,#5, AL) -> exe_cmd=0010, wb_en=1, imm=1, shift_operand=0x005, dest=1, two_src=0.
REQ-034 wb_en_in=1, wb_dest=3, wb_value=0xDEADBEEF, same cycle rn=3 -> val_rn=0xDEADBEEF combinationally, still 0xDEADBEEF after the edge.
REQ-035 0x0A000004 (BEQ) with status Z=0 -> b=0 and all control 0; with Z=1 -> b=1, signed_imm_24=0x000004.
REQ-036 0xE5821000 (STR R1,[R2]) -> mem_w_en=1, wb_en=0, src2=1, two_src=1, exe_cmd=0010.
REQ-037 Any valid ADD with hazard=1 -> all control 0 while val_rn and val_rm are still driven.
